// File: rtl/hls_handshake_profiler_if.sv
// Handshake, control and read-back bundle between a kernel testbench/board wrapper and the profiler.
interface hls_handshake_profiler_if #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CNT_W  = 32
) ();
  localparam int unsigned RDCH_W = $clog2(NUM_CH) + 1;

  logic [NUM_CH-1:0] ap_start;
  logic [NUM_CH-1:0] ap_ready;
  logic [NUM_CH-1:0] ap_done;
  logic [NUM_CH-1:0] ap_continue;
  logic              finish;
  logic              clear;
  logic              rd_en;
  logic [RDCH_W-1:0] rd_ch;
  logic [2:0]        rd_sel;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_data;
  logic              frozen;

  // Side that drives the handshakes and issues reads.
  modport master (
    output ap_start, ap_ready, ap_done, ap_continue, finish, clear, rd_en, rd_ch, rd_sel,
    input  rd_valid, rd_data, frozen
  );

  // Profiler side.
  modport slave (
    input  ap_start, ap_ready, ap_done, ap_continue, finish, clear, rd_en, rd_ch, rd_sel,
    output rd_valid, rd_data, frozen
  );
endinterface

// File: rtl/hls_handshake_profiler.sv
// Per-channel profiler for HLS block-level handshakes: start/txn counts, start-to-done
// latency (last/min/max), output-stall cycles, read back through a registered port.
module hls_handshake_profiler #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned LAT_W  = 24
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  hls_handshake_profiler_if.slave  bus
);
  localparam int unsigned RDCH_W = $clog2(NUM_CH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t            r_state    [NUM_CH];
  logic [LAT_W-1:0]  r_lat_cnt  [NUM_CH];
  logic [LAT_W-1:0]  r_last_lat [NUM_CH];
  logic [LAT_W-1:0]  r_min_lat  [NUM_CH];
  logic [LAT_W-1:0]  r_max_lat  [NUM_CH];
  logic [CNT_W-1:0]  r_txn      [NUM_CH];
  logic [CNT_W-1:0]  r_starts   [NUM_CH];
  logic [CNT_W-1:0]  r_stall    [NUM_CH];
  logic [NUM_CH-1:0] r_ovf;
  logic              r_frozen;
  logic              r_rd_valid;
  logic [CNT_W-1:0]  r_rd_data;

  logic [LAT_W-1:0]  w_lat_inc  [NUM_CH];
  logic [NUM_CH-1:0] w_lat_sat;
  logic [LAT_W-1:0]  w_sample   [NUM_CH];
  logic [NUM_CH-1:0] w_sample_en;
  logic [CNT_W-1:0]  w_rd_mux;

  // Saturating latency increment and the latency value sampled on a completing done.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_lat_sat[i]   = &r_lat_cnt[i];
      w_lat_inc[i]   = w_lat_sat[i] ? r_lat_cnt[i] : r_lat_cnt[i] + LAT_W'(1);
      w_sample[i]    = (r_state[i] == S_IDLE) ? LAT_W'(1) : w_lat_inc[i];
      w_sample_en[i] = bus.ap_done[i] &&
                       (((r_state[i] == S_IDLE) && bus.ap_start[i]) || (r_state[i] == S_RUN));
    end
  end

  // Per-channel handshake FSM and statistics; clear outranks everything, frozen holds all.
  always_ff @(posedge i_clock) begin
    if (i_reset || bus.clear) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i]    <= S_IDLE;
        r_lat_cnt[i]  <= '0;
        r_last_lat[i] <= '0;
        r_min_lat[i]  <= '1;
        r_max_lat[i]  <= '0;
        r_txn[i]      <= '0;
        r_starts[i]   <= '0;
        r_stall[i]    <= '0;
      end
      r_ovf <= '0;
    end else if (!r_frozen) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.ap_start[i] && bus.ap_ready[i]) begin
          if (&r_starts[i]) r_ovf[i] <= 1'b1;
          else              r_starts[i] <= r_starts[i] + CNT_W'(1);
        end
        if (bus.ap_done[i] && bus.ap_continue[i]) begin
          if (&r_txn[i]) r_ovf[i] <= 1'b1;
          else           r_txn[i] <= r_txn[i] + CNT_W'(1);
        end
        if (w_sample_en[i]) begin
          r_last_lat[i] <= w_sample[i];
          if (w_sample[i] < r_min_lat[i]) r_min_lat[i] <= w_sample[i];
          if (w_sample[i] > r_max_lat[i]) r_max_lat[i] <= w_sample[i];
        end
        case (r_state[i])
          S_IDLE: begin
            if (bus.ap_start[i]) begin
              r_lat_cnt[i] <= LAT_W'(1);
              if (bus.ap_done[i]) r_state[i] <= bus.ap_continue[i] ? S_IDLE : S_STALL;
              else                r_state[i] <= S_RUN;
            end
          end
          S_RUN: begin
            r_lat_cnt[i] <= w_lat_inc[i];
            if (w_lat_sat[i]) r_ovf[i] <= 1'b1;
            if (bus.ap_done[i]) r_state[i] <= bus.ap_continue[i] ? S_IDLE : S_STALL;
          end
          S_STALL: begin
            if (bus.ap_continue[i]) begin
              r_state[i] <= S_IDLE;
            end else if (&r_stall[i]) begin
              r_ovf[i] <= 1'b1;
            end else begin
              r_stall[i] <= r_stall[i] + CNT_W'(1);
            end
          end
          default: r_state[i] <= S_IDLE;
        endcase
      end
    end
  end

  // Sticky freeze once the run reports finish.
  always_ff @(posedge i_clock) begin
    if (i_reset || bus.clear) r_frozen <= 1'b0;
    else if (bus.finish)      r_frozen <= 1'b1;
  end

  // Random-access statistics selector; out-of-range channel or selector reads zero.
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.rd_ch == RDCH_W'(i)) begin
        case (bus.rd_sel)
          3'd0:    w_rd_mux = r_txn[i];
          3'd1:    w_rd_mux = r_starts[i];
          3'd2:    w_rd_mux = CNT_W'(r_last_lat[i]);
          3'd3:    w_rd_mux = CNT_W'(r_min_lat[i]);
          3'd4:    w_rd_mux = CNT_W'(r_max_lat[i]);
          3'd5:    w_rd_mux = r_stall[i];
          3'd6:    w_rd_mux = CNT_W'({r_ovf[i], r_state[i]});
          default: w_rd_mux = '0;
        endcase
      end
    end
  end

  // One register stage on the read port.
  always_ff @(posedge i_clock) begin
    if (i_reset || bus.clear) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= bus.rd_en;
      r_rd_data  <= bus.rd_en ? w_rd_mux : '0;
    end
  end

  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = r_rd_data;
  assign bus.frozen   = r_frozen;
endmodule

// File: tb/tb_hls_handshake_profiler.sv
// Bench for hls_handshake_profiler: read results go through a scoreboard queue,
// main statistics are checked from a vector table, corner cases by hand.
module tb_hls_handshake_profiler;
  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;

  typedef struct {
    int          ch;
    int          sel;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  sb_t  sb_q  [$];
  sb_t  ssb_q [$];
  vec_t tbl   [$];
  sb_t  e_main;
  sb_t  e_sat;

  hls_handshake_profiler_if #(.NUM_CH(8), .CNT_W(32)) bus ();
  hls_handshake_profiler_if #(.NUM_CH(2), .CNT_W(4))  sbus ();

  hls_handshake_profiler #(.NUM_CH(8), .CNT_W(32), .LAT_W(24)) u_dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  hls_handshake_profiler #(.NUM_CH(2), .CNT_W(4), .LAT_W(4)) u_sat (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard for the main instance: every rd_valid pops one expected read.
  always @(negedge clk) begin
    if (bus.rd_valid) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL spurious_rd_valid: rd_valid=1 rd_data=%0h required no read pending", bus.rd_data);
      end else begin
        e_main = sb_q.pop_front();
        if (bus.rd_data !== e_main.exp) begin
          fails++;
          $display("FAIL %s: rd_data=%0h required %0h", e_main.name, bus.rd_data, e_main.exp);
        end
      end
    end
  end

  // Scoreboard for the narrow saturation instance.
  always @(negedge clk) begin
    if (sbus.rd_valid) begin
      tests++;
      if (ssb_q.size() == 0) begin
        fails++;
        $display("FAIL sat_spurious_rd_valid: rd_data=%0h required no read pending", sbus.rd_data);
      end else begin
        e_sat = ssb_q.pop_front();
        if ({28'd0, sbus.rd_data} !== e_sat.exp) begin
          fails++;
          $display("FAIL %s: rd_data=%0h required %0h", e_sat.name, sbus.rd_data, e_sat.exp);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    bus.rd_en  = 1'b0;
    sbus.rd_en = 1'b0;
  endtask

  task automatic rd_req(input int ch, input int sel, input logic [31:0] exp, input string name);
    bus.rd_en  = 1'b1;
    bus.rd_ch  = 4'(ch);
    bus.rd_sel = 3'(sel);
    sb_q.push_back('{exp, name});
  endtask

  task automatic srd_req(input int ch, input int sel, input logic [31:0] exp, input string name);
    sbus.rd_en  = 1'b1;
    sbus.rd_ch  = 2'(ch);
    sbus.rd_sel = 3'(sel);
    ssb_q.push_back('{exp, name});
  endtask

  task automatic check(input logic [31:0] act, input logic [31:0] exp, input string name);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // One transaction on a channel: start at cycle 0, done at cycle lat-1, then
  // stall_cyc STALL cycles with continue low before the release cycle.
  task automatic run_ch(input int ch, input int lat, input int stall_cyc);
    bus.ap_start[ch] = 1'b1;
    bus.ap_ready[ch] = 1'b1;
    if (lat == 1) begin
      bus.ap_done[ch]     = 1'b1;
      bus.ap_continue[ch] = (stall_cyc == 0);
    end
    cyc();
    bus.ap_start[ch] = 1'b0;
    bus.ap_ready[ch] = 1'b0;
    if (lat > 1) begin
      repeat (lat - 2) cyc();
      bus.ap_done[ch]     = 1'b1;
      bus.ap_continue[ch] = (stall_cyc == 0);
      cyc();
    end
    if (stall_cyc > 0) begin
      repeat (stall_cyc) cyc();
      bus.ap_continue[ch] = 1'b1;
      cyc();
    end
    bus.ap_done[ch]     = 1'b0;
    bus.ap_continue[ch] = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;

    // Expected statistics after the main per-channel scenario.
    tbl.push_back('{0, 0, 32'd1,  "ch0_txn"});
    tbl.push_back('{0, 1, 32'd1,  "ch0_starts"});
    tbl.push_back('{0, 2, 32'd6,  "ch0_last_lat"});
    tbl.push_back('{0, 3, 32'd6,  "ch0_min_lat"});
    tbl.push_back('{0, 4, 32'd6,  "ch0_max_lat"});
    tbl.push_back('{0, 5, 32'd0,  "ch0_stall"});
    tbl.push_back('{0, 6, 32'd0,  "ch0_status"});
    tbl.push_back('{1, 0, 32'd2,  "ch1_txn"});
    tbl.push_back('{1, 2, 32'd9,  "ch1_last_lat"});
    tbl.push_back('{1, 3, 32'd3,  "ch1_min_lat"});
    tbl.push_back('{1, 4, 32'd9,  "ch1_max_lat"});
    tbl.push_back('{2, 0, 32'd1,  "ch2_txn"});
    tbl.push_back('{2, 2, 32'd2,  "ch2_last_lat"});
    tbl.push_back('{2, 5, 32'd4,  "ch2_stall"});
    tbl.push_back('{2, 6, 32'd0,  "ch2_status"});
    tbl.push_back('{3, 1, 32'd11, "ch3_starts"});
    tbl.push_back('{3, 0, 32'd2,  "ch3_txn"});
    tbl.push_back('{3, 2, 32'd1,  "ch3_last_lat"});
    tbl.push_back('{3, 3, 32'd1,  "ch3_min_lat"});
    tbl.push_back('{3, 4, 32'd11, "ch3_max_lat"});
    tbl.push_back('{4, 3, 32'h00FF_FFFF, "ch4_min_lat_unsampled"});
    tbl.push_back('{4, 0, 32'd0,  "ch4_txn"});
    tbl.push_back('{8, 0, 32'd0,  "rd_ch_out_of_range"});
    tbl.push_back('{0, 7, 32'd0,  "rd_sel_7"});

    bus.ap_start     = '0;
    bus.ap_ready     = '0;
    bus.ap_done      = '0;
    bus.ap_continue  = '1;
    bus.finish       = 1'b0;
    bus.clear        = 1'b0;
    bus.rd_en        = 1'b0;
    bus.rd_ch        = '0;
    bus.rd_sel       = '0;
    sbus.ap_start    = '0;
    sbus.ap_ready    = '0;
    sbus.ap_done     = '0;
    sbus.ap_continue = '1;
    sbus.finish      = 1'b0;
    sbus.clear       = 1'b0;
    sbus.rd_en       = 1'b0;
    sbus.rd_ch       = '0;
    sbus.rd_sel      = '0;

    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    check(32'(bus.frozen),   32'd0, "reset_frozen");
    check(32'(bus.rd_valid), 32'd0, "reset_rd_valid");
    check(bus.rd_data,       32'd0, "reset_rd_data");
    rd_req(0, 3, 32'h00FF_FFFF, "reset_min_lat"); cyc();
    rd_req(0, 0, 32'd0,         "reset_txn");     cyc();
    rd_req(0, 6, 32'd0,         "reset_status");  cyc();

    // ch0: done 5 cycles after start -> latency 6.
    run_ch(0, 6, 0);
    // ch1: latency 3 then 9.
    run_ch(1, 3, 0);
    run_ch(1, 9, 0);

    // ch2: latency 2, then held off for 4 STALL cycles; reads see pre-update stats.
    bus.ap_start[2] = 1'b1;
    bus.ap_ready[2] = 1'b1;
    cyc();
    bus.ap_start[2]    = 1'b0;
    bus.ap_ready[2]    = 1'b0;
    bus.ap_done[2]     = 1'b1;
    bus.ap_continue[2] = 1'b0;
    cyc();
    for (int k = 0; k < 4; k++) begin
      rd_req(2, 6, 32'd2, "ch2_status_stall");
      cyc();
    end
    bus.ap_continue[2] = 1'b1;
    rd_req(2, 0, 32'd0, "ch2_txn_in_release_cycle");
    cyc();
    bus.ap_done[2] = 1'b0;
    rd_req(2, 0, 32'd1, "ch2_txn_after_release");
    cyc();

    // ch3: start/ready held 10 cycles, done next cycle (lat 11), then a same-cycle start+done.
    bus.ap_start[3] = 1'b1;
    bus.ap_ready[3] = 1'b1;
    repeat (10) cyc();
    bus.ap_start[3] = 1'b0;
    bus.ap_ready[3] = 1'b0;
    bus.ap_done[3]  = 1'b1;
    cyc();
    bus.ap_done[3] = 1'b0;
    rd_req(3, 1, 32'd10, "ch3_starts_held"); cyc();
    rd_req(3, 2, 32'd11, "ch3_lat_held");    cyc();
    run_ch(3, 1, 0);

    foreach (tbl[i]) begin
      rd_req(tbl[i].ch, tbl[i].sel, tbl[i].exp, tbl[i].name);
      cyc();
    end

    // finish mid-RUN on ch0: later done and starts are ignored.
    bus.ap_start[0] = 1'b1;
    bus.ap_ready[0] = 1'b1;
    cyc();
    bus.ap_start[0] = 1'b0;
    bus.ap_ready[0] = 1'b0;
    repeat (2) cyc();
    bus.finish = 1'b1;
    cyc();
    bus.finish = 1'b0;
    check(32'(bus.frozen), 32'd1, "frozen_after_finish");
    repeat (2) cyc();
    bus.ap_done[0] = 1'b1;
    cyc();
    bus.ap_done[0]  = 1'b0;
    bus.ap_start[5] = 1'b1;
    bus.ap_ready[5] = 1'b1;
    cyc();
    bus.ap_start[5] = 1'b0;
    bus.ap_ready[5] = 1'b0;
    rd_req(0, 0, 32'd1, "frozen_ch0_txn");      cyc();
    rd_req(0, 6, 32'd1, "frozen_ch0_status");   cyc();
    rd_req(0, 2, 32'd6, "frozen_ch0_last_lat"); cyc();
    rd_req(5, 1, 32'd0, "frozen_ch5_starts");   cyc();
    check(32'(bus.frozen), 32'd1, "frozen_held");

    // clear: statistics back to reset values and freeze released.
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    check(32'(bus.frozen), 32'd0, "clear_frozen");
    rd_req(0, 0, 32'd0,         "clear_ch0_txn");    cyc();
    rd_req(0, 3, 32'h00FF_FFFF, "clear_ch0_min_lat"); cyc();
    rd_req(0, 6, 32'd0,         "clear_ch0_status"); cyc();
    rd_req(1, 4, 32'd0,         "clear_ch1_max_lat"); cyc();
    rd_req(3, 1, 32'd0,         "clear_ch3_starts"); cyc();
    rd_req(2, 5, 32'd0,         "clear_ch2_stall");  cyc();

    // clear in the same cycle as a completing done wins.
    bus.ap_start[0] = 1'b1;
    bus.ap_ready[0] = 1'b1;
    cyc();
    bus.ap_start[0] = 1'b0;
    bus.ap_ready[0] = 1'b0;
    bus.ap_done[0]  = 1'b1;
    bus.clear       = 1'b1;
    cyc();
    bus.ap_done[0] = 1'b0;
    bus.clear      = 1'b0;
    rd_req(0, 0, 32'd0, "clear_done_txn");      cyc();
    rd_req(0, 1, 32'd0, "clear_done_starts");   cyc();
    rd_req(0, 6, 32'd0, "clear_done_status");   cyc();
    rd_req(0, 2, 32'd0, "clear_done_last_lat"); cyc();

    // Saturation on the 4-bit instance: 17 single-cycle transactions.
    sbus.ap_start[0] = 1'b1;
    sbus.ap_ready[0] = 1'b1;
    sbus.ap_done[0]  = 1'b1;
    repeat (17) cyc();
    sbus.ap_start[0] = 1'b0;
    sbus.ap_ready[0] = 1'b0;
    sbus.ap_done[0]  = 1'b0;
    srd_req(0, 0, 32'd15, "sat_txn");     cyc();
    srd_req(0, 1, 32'd15, "sat_starts");  cyc();
    srd_req(0, 6, 32'd4,  "sat_status_ovf"); cyc();
    srd_req(1, 6, 32'd0,  "sat_ch1_status"); cyc();
    srd_req(2, 0, 32'd0,  "sat_rd_ch_out_of_range"); cyc();

    repeat (3) cyc();
    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL missing_rd_valid: %0d reads pending required 0", sb_q.size());
    end
    if (ssb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL sat_missing_rd_valid: %0d reads pending required 0", ssb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
